// File: rtl/fifo_reader.sv
// FIFO-to-stream reader: pops a first-word-fall-through-less FIFO into a 2-entry skid buffer.
// Optional delivered-beat counter on rd_count when FIFO_RD_COUNT_EN is defined.
module fifo_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                  rd_clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
`ifdef FIFO_RD_COUNT_EN
    ,
    output logic [15:0]           rd_count
`endif
);

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    localparam int BW = (BURST_LEN > 2) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

    logic [1:0]            occ;
    logic                  inflight;
    logic                  rst_q;
    logic [DATA_WIDTH-1:0] tail;
    logic [BW-1:0]         beat;
    logic                  pop;
    logic [2:0]            level;

    // Head entry is m_data itself, so the output is always a register.
    assign m_valid    = (occ != OCC_EMPTY) && !rst;
    assign pop        = m_valid && m_ready;
    assign level      = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    // rst_q keeps the pop request low for one cycle after reset releases.
    assign fifo_rd_en = !fifo_empty && !rst && !rst_q && (level < 3'd2);
    assign m_last     = m_valid && (beat == LAST_BEAT);

    always_ff @(posedge rd_clk) begin
        rst_q <= rst;
        if (rst) begin
            occ      <= OCC_EMPTY;
            inflight <= 1'b0;
            beat     <= '0;
            m_data   <= '0;
            tail     <= '0;
        end else begin
            inflight <= fifo_rd_en;
            if (pop) begin
                beat <= (beat == LAST_BEAT) ? '0 : beat + BW'(1);
            end
            case (occ)
                OCC_EMPTY: begin
                    if (inflight) begin
                        m_data <= fifo_dout;
                        occ    <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (pop && inflight) begin
                        m_data <= fifo_dout;
                    end else if (pop) begin
                        occ <= OCC_EMPTY;
                    end else if (inflight) begin
                        tail <= fifo_dout;
                        occ  <= OCC_TWO;
                    end
                end
                OCC_TWO: begin
                    if (pop) begin
                        m_data <= tail;
                        if (inflight) begin
                            tail <= fifo_dout;
                        end else begin
                            occ <= OCC_ONE;
                        end
                    end
                end
                default: occ <= OCC_EMPTY;
            endcase
        end
    end

`ifdef FIFO_RD_COUNT_EN
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            rd_count <= 16'd0;
        end else if (pop) begin
            rd_count <= rd_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: emulated upstream FIFO, queue-based reference of the
// buffered words, per-cycle comparison plus directed literal scenarios.
module tb_fifo_reader;
    localparam int DW = 8;
    localparam int BL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_empty;
    logic [DW-1:0] fifo_dout;
    logic          fifo_rd_en;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
`ifdef FIFO_RD_COUNT_EN
    logic [15:0]   rd_count;
`endif

    always #5 clk = ~clk;

    fifo_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .rd_clk(clk),
        .rst(rst),
        .fifo_empty(fifo_empty),
        .fifo_dout(fifo_dout),
        .fifo_rd_en(fifo_rd_en),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
        .m_last(m_last)
`ifdef FIFO_RD_COUNT_EN
        ,
        .rd_count(rd_count)
`endif
    );

    // stimulus knobs
    bit rst_v, ready_v, hold_v;
    // reference: upstream FIFO contents, words held downstream, word in transit
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    bit            have_tr;
    logic [DW-1:0] tr_word;
    bit            rst_prev;
    int            beats;
    logic [15:0]   cnt;
    // sampled values and logs for the directed checks
    logic          s_rd, s_valid, s_last;
    logic [DW-1:0] s_data;
    logic [15:0]   s_count;
    logic [DW-1:0] beat_log[$];
    bit            last_log[$];
    int            time_log[$];
    int            rd_pulses, valid_cycles, cyc, pop_total;
    int            n_cmp, n_bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        beat_log.delete();
        last_log.delete();
        time_log.delete();
        rd_pulses    = 0;
        valid_cycles = 0;
    endtask

    // One clock cycle: drive, sample, compare against the reference, advance it.
    task automatic step();
        bit e_valid, e_pop, e_rd, e_last;
        @(negedge clk);
        rst        = rst_v;
        m_ready    = ready_v;
        fifo_empty = hold_v || (fifo_q.size() == 0);
        fifo_dout  = have_tr ? tr_word : DW'($urandom);
        #1;
        e_valid = (exp_q.size() != 0) && !rst_v;
        e_pop   = e_valid && ready_v;
        e_rd    = !fifo_empty && !rst_v && !rst_prev &&
                  ((exp_q.size() + int'(have_tr) - int'(e_pop)) < 2);
        e_last  = e_valid && (beats == BL - 1);
        check("fifo_rd_en", fifo_rd_en, e_rd);
        check("m_valid", m_valid, e_valid);
        check("m_last", m_last, e_last);
        if (e_valid) check("m_data", m_data, exp_q[0]);
        s_rd = fifo_rd_en; s_valid = m_valid; s_last = m_last; s_data = m_data;
`ifdef FIFO_RD_COUNT_EN
        check("rd_count", rd_count, cnt);
        s_count = rd_count;
`else
        s_count = 16'd0;
`endif
        if (fifo_rd_en) rd_pulses++;
        if (m_valid) valid_cycles++;
        if (e_pop) begin
            beat_log.push_back(exp_q[0]);
            last_log.push_back(e_last);
            time_log.push_back(cyc);
        end
        rst_prev = rst_v;
        if (rst_v) begin
            exp_q.delete();
            have_tr = 0;
            beats   = 0;
            cnt     = 16'd0;
        end else begin
            if (e_pop) begin
                void'(exp_q.pop_front());
                beats = (beats + 1) % BL;
                cnt   = cnt + 16'd1;
                pop_total++;
            end
            if (have_tr) begin
                exp_q.push_back(tr_word);
                have_tr = 0;
            end
            if (e_rd) begin
                tr_word = fifo_q.pop_front();
                have_tr = 1;
            end
        end
        cyc++;
    endtask

    task automatic load(input int first, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(DW'(first + i));
    endtask

    task automatic check_beats(input string name, input int first, input int n, input int last_idx);
        check({name, "_n"}, beat_log.size(), n);
        for (int i = 0; i < n && i < beat_log.size(); i++) begin
            check({name, "_data"}, beat_log[i], first + i);
            check({name, "_last"}, last_log[i], (i == last_idx) ? 1 : 0);
        end
    endtask

    initial begin
        int first_rd;
        n_cmp = 0; n_bad = 0; cyc = 0; pop_total = 0;
        have_tr = 0; rst_prev = 1; beats = 0; cnt = 16'd0;
        rst = 1'b1; m_ready = 1'b0; fifo_empty = 1'b0; fifo_dout = '0;
        rst_v = 1; ready_v = 0; hold_v = 0;
        @(posedge clk);

        // reset with a non-empty FIFO holding 0x01..0x04
        load(1, 4);
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_rd_en", s_rd, 0);
            check("rst_valid", s_valid, 0);
            check("rst_last", s_last, 0);
            check("rst_count", s_count, 0);
        end
        rst_v = 0; ready_v = 1;
        step();
        check("post_rst_rd_en", s_rd, 0);
        check("post_rst_valid", s_valid, 0);
        check("post_rst_last", s_last, 0);
        check("post_rst_data", s_data, 0);

        // streaming: first beat two cycles after the first pop request, then back to back
        clear_logs();
        first_rd = -1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (s_rd && first_rd < 0) first_rd = cyc - 1;
        end
        check_beats("stream", 1, 4, 3);
        for (int i = 0; i < time_log.size(); i++)
            check("stream_time", time_log[i], first_rd + 2 + i);

        // backpressure: only two words popped while stalled
        clear_logs();
        load(1, 6);
        ready_v = 0;
        for (int i = 0; i < 10; i++) step();
        check("bp_pulses", rd_pulses, 2);
        check("bp_hold_data", s_data, 8'h01);
        check("bp_hold_valid", s_valid, 1);
        ready_v = 1;
        for (int i = 0; i < 12; i++) step();
        check_beats("bp", 1, 6, 3);

        // empty FIFO: nothing requested, nothing emitted
        clear_logs();
        hold_v = 1;
        for (int i = 0; i < 20; i++) step();
        check("empty_pulses", rd_pulses, 0);
        check("empty_valid", valid_cycles, 0);
        hold_v = 0;

        // reset mid-stream with the buffer full
        load(8'h20, 8);
        clear_logs();
        for (int i = 0; i < 20 && beat_log.size() < 2; i++) step();
        ready_v = 0;
        for (int i = 0; i < 3; i++) step();
        check("mid_full_valid", s_valid, 1);
        rst_v = 1;
        step();
        check("mid_rst_valid", s_valid, 0);
        rst_v = 0;
        fifo_q.delete();
        load(8'h10, 4);
        step();
        check("mid_after_valid", s_valid, 0);
        clear_logs();
        ready_v = 1;
        for (int i = 0; i < 10; i++) step();
        check_beats("mid", 8'h10, 4, 3);

        // randomized traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            if (fifo_q.size() < 4 && $urandom_range(0, 3) == 0) load($urandom_range(0, 255), $urandom_range(1, 5));
            ready_v = ($urandom_range(0, 3) != 0);
            hold_v  = ($urandom_range(0, 5) == 0);
            rst_v   = ($urandom_range(0, 149) == 0);
            step();
        end
        rst_v = 0; hold_v = 0;

`ifdef FIFO_RD_COUNT_EN
        // counter: 10 pops, then run to 16'hFFFF and wrap
        rst_v = 1; step(); rst_v = 0;
        fifo_q.delete();
        pop_total = 0;
        ready_v = 1;
        for (int i = 0; i < 100 && pop_total < 10; i++) begin
            if (fifo_q.size() < 4) load(i, 4);
            ready_v = (pop_total < 9) ? 1 : 0;
            if (pop_total == 9 && exp_q.size() != 0) ready_v = 1;
            step();
        end
        ready_v = 0; step();
        check("count_10", s_count, 16'd10);
        ready_v = 1;
        for (int i = 0; i < 70000 && pop_total < 65535; i++) begin
            if (fifo_q.size() < 4) load(i, 4);
            ready_v = (pop_total < 65534) || (exp_q.size() != 0);
            step();
            if (pop_total >= 65535) ready_v = 0;
        end
        ready_v = 0; step();
        check("count_ffff", s_count, 16'hFFFF);
        ready_v = 1;
        for (int i = 0; i < 20 && pop_total < 65536; i++) begin
            if (fifo_q.size() < 4) load(i, 4);
            step();
        end
        ready_v = 0; step();
        check("count_wrap", s_count, 16'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
